// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: after a piece locks, drops full rows bottom-up, compacts the rest and blanks the top.
// Ports: Clk/Reset (sync, active-high); start pulse; row-wide RAM port rd_addr/rd_data (1-cycle latency),
// wr_en/wr_addr/wr_data; BOARD_BUSY, done; lines_cleared, score_add, lines_total, fall_period to the HUD.
// Optional LINE_CLEAR_LEVEL_EN adds level-scaled scoring and a level-dependent fall_period.
module line_clear_ctrl #(
  parameter int ROWS        = 20,
  parameter int COLS        = 10,
  parameter int CELL_W      = 3,
  parameter int LEVEL_SPEED = 60
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  output logic [4:0]               rd_addr,
  input  logic [COLS*CELL_W-1:0]   rd_data,
  output logic                     wr_en,
  output logic [4:0]               wr_addr,
  output logic [COLS*CELL_W-1:0]   wr_data,
  output logic                     BOARD_BUSY,
  output logic                     done,
  output logic [4:0]               lines_cleared,
  output logic [11:0]              score_add,
  output logic [15:0]              lines_total,
  output logic [5:0]               fall_period
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, EVAL = 3'd2, FILL = 3'd3, DONE = 3'd4;
  logic [2:0]  state, state_n;
  logic [4:0]  src, dst, cnt, cnt_n;
  logic        full, keep;
  logic [11:0] base, score_n;
  logic [16:0] sum;
  logic [15:0] total_n;
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < COLS; i++) full = full & (|rd_data[i*CELL_W +: CELL_W]);
  end
  // cnt_n already includes the row under evaluation, so FILL/DONE choice and stats see the final count
  assign cnt_n   = cnt + 5'((state == EVAL && full) ? 1 : 0);
  assign keep    = state == EVAL && !full && dst != src;
  assign state_n = state == IDLE ? (start ? READ : IDLE) :
                   state == READ ? EVAL :
                   state == EVAL ? (src != 5'd0 ? READ : cnt_n != 5'd0 ? FILL : DONE) :
                   state == FILL ? (dst == 5'd0 ? DONE : FILL) : IDLE;
  assign rd_addr = state == READ ? src : 5'd0;
  // Reset gates the strobe immediately so an interrupted sequence writes nothing more
  assign wr_en   = !Reset && (keep || state == FILL);
  assign wr_addr = wr_en ? dst : 5'd0;
  assign wr_data = (wr_en && keep) ? rd_data : '0;
  assign done    = state == DONE;
  assign base    = cnt_n >= 5'd4 ? 12'd800 : cnt_n == 5'd3 ? 12'd500 :
                   cnt_n == 5'd2 ? 12'd300 : cnt_n == 5'd1 ? 12'd100 : 12'd0;
  assign sum     = {1'b0, lines_total} + {12'd0, cnt_n};
  assign total_n = sum[16] ? 16'hFFFF : sum[15:0];
`ifdef LINE_CLEAR_LEVEL_EN
  logic [3:0]  lvl_o, lvl_n;
  logic [15:0] scaled;
  logic [5:0]  fall_n;
  int          fall_raw;
  always_comb begin
    lvl_o    = lines_total >= 16'd100 ? 4'd10 : 4'(lines_total / 16'd10);
    lvl_n    = total_n >= 16'd100 ? 4'd10 : 4'(total_n / 16'd10);
    scaled   = {4'd0, base} * ({12'd0, lvl_o} + 16'd1);
    score_n  = scaled > 16'h0FFF ? 12'hFFF : scaled[11:0];
    fall_raw = LEVEL_SPEED - 5 * int'(lvl_n);
    fall_n   = fall_raw < 10 ? 6'd10 : 6'(fall_raw);
  end
  always_ff @(posedge Clk)
    if (Reset) fall_period <= 6'(LEVEL_SPEED);
    else if (state_n == DONE && state != DONE) fall_period <= fall_n;
`else
  assign score_n     = base;
  assign fall_period = 6'(LEVEL_SPEED);
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      BOARD_BUSY    <= 1'b0;
      src           <= 5'd0;
      dst           <= 5'd0;
      cnt           <= 5'd0;
      lines_cleared <= 5'd0;
      score_add     <= 12'd0;
      lines_total   <= 16'd0;
    end else begin
      state      <= state_n;
      BOARD_BUSY <= state_n != IDLE;
      if (state == IDLE && start) begin
        src <= 5'(ROWS - 1);
        dst <= 5'(ROWS - 1);
        cnt <= 5'd0;
      end
      if (state == EVAL) begin
        cnt <= cnt_n;
        if (!full) dst <= dst - 5'd1;
        if (src != 5'd0) src <= src - 5'd1;
      end
      if (state == FILL) dst <= dst - 5'd1;
      // Results publish on entry to DONE so they are valid during the done pulse
      if (state_n == DONE && state != DONE) begin
        lines_cleared <= cnt_n;
        score_add     <= score_n;
        lines_total   <= total_n;
      end
    end
  end
endmodule
